sram_port_arbiter: RTL

- Shares the single-port 4096x16 sample SRAM between two requesters:
  - the sample loader (writes);
  - the k-means distance engine (reads).
- Also provides a self-timed clear sequence that zeroes the whole array between runs.
- Sits between the CORE datapath and the SHAB90_4096X16X1CM16 macro.
- Owns every SRAM pin, and registers each one.

---
 rtl/sram_port_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Arbitrates the single-port sample SRAM between the loader (writes) and the
// distance engine (reads), and runs a self-timed whole-array clear.
module sram_port_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_di,
    output logic              mem_web,
    output logic              mem_cs,
    input  logic [DATA_W-1:0] mem_do
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    typedef enum logic {ST_SERVE, ST_CLEAR} state_t;

    state_t             state, state_nxt;
    logic [BURST_W-1:0] burst_cnt, burst_nxt;
    logic [ADDR_W-1:0]  clr_cnt, clr_nxt;
    logic               clr_last;
    logic               rd_win, wr_win;
    logic               rd_p1, rd_p2;

    assign clr_last = &clr_cnt;
    assign clr_busy = (state == ST_CLEAR);

    // Handshake: a request is held with its address/data stable until its
    // grant is high in the same cycle; the transfer happens in that cycle.
    assign rd_gnt = rd_win & rst_n;
    assign wr_gnt = wr_win & rst_n;

    always_comb begin
        state_nxt = state;
        clr_nxt   = clr_cnt;
        rd_win    = 1'b0;
        wr_win    = 1'b0;
        case (state)
            ST_SERVE: begin
                if (clr_start) begin
                    state_nxt = ST_CLEAR;
                    clr_nxt   = '0;
                end else if (rd_req && (burst_cnt < BURST_MAX)) begin
                    rd_win = 1'b1;
                end else if (wr_req) begin
                    wr_win = 1'b1;
                end
            end
            ST_CLEAR: begin
                clr_nxt = clr_cnt + 1'b1;
                if (clr_last) state_nxt = ST_SERVE;
            end
            default: state_nxt = ST_SERVE;
        endcase
    end

    // Reads may only starve a pending write for MAX_BURST consecutive grants.
    always_comb begin
        burst_nxt = burst_cnt;
        if (!wr_req || wr_win)
            burst_nxt = '0;
        else if (rd_win && (burst_cnt != BURST_MAX))
            burst_nxt = burst_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SERVE;
            burst_cnt <= '0;
            clr_cnt   <= '0;
            clr_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            clr_cnt   <= clr_nxt;
            clr_done  <= (state == ST_CLEAR) && clr_last;
        end
    end

    // Every SRAM pin is registered; address and data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_a   <= '0;
            mem_di  <= '0;
            mem_web <= 1'b1;
            mem_cs  <= 1'b0;
        end else if (state == ST_CLEAR) begin
            mem_a   <= clr_cnt;
            mem_di  <= '0;
            mem_web <= 1'b0;
            mem_cs  <= 1'b1;
        end else if (wr_win) begin
            mem_a   <= wr_addr;
            mem_di  <= wr_data;
            mem_web <= 1'b0;
            mem_cs  <= 1'b1;
        end else if (rd_win) begin
            mem_a   <= rd_addr;
            mem_web <= 1'b1;
            mem_cs  <= 1'b1;
        end else begin
            mem_web <= 1'b1;
            mem_cs  <= 1'b0;
        end
    end

    // Read return: pins registered, SRAM samples, mem_do captured -> 3 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_p1    <= 1'b0;
            rd_p2    <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_p1    <= rd_win;
            rd_p2    <= rd_p1;
            rd_valid <= rd_p2;
            if (rd_p2) rd_data <= mem_do;
        end
    end

endmodule
